// File: rtl/bp_cfg_link_regfile_pkg.sv
// Shared types and constants for the per-core config-link register file:
// response FSM states, cache/CCE mode encodings and the cfg address map.
package bp_cfg_link_regfile_pkg;

    typedef enum logic [0:0] {
        e_cfg_idle = 1'b0,
        e_cfg_resp = 1'b1
    } bp_cfg_state_e;

    typedef enum logic [1:0] {
        e_cache_mode_normal   = 2'd0,
        e_cache_mode_uncached = 2'd1,
        e_cache_mode_nonspec  = 2'd2,
        e_cache_mode_rsvd     = 2'd3
    } bp_cache_mode_e;

    typedef enum logic [0:0] {
        e_cce_mode_normal   = 1'b0,
        e_cce_mode_uncached = 1'b1
    } bp_cce_mode_e;

    // cfg address map
    localparam logic [15:0] cfg_addr_reset_gp   = 16'h0001;
    localparam logic [15:0] cfg_addr_freeze_gp  = 16'h0002;
    localparam logic [15:0] cfg_addr_core_id_gp = 16'h0005;
    localparam logic [15:0] cfg_addr_icache_gp  = 16'h0022;
    localparam logic [15:0] cfg_addr_npc_lo_gp  = 16'h0040;
    localparam logic [15:0] cfg_addr_npc_hi_gp  = 16'h0041;
    localparam logic [15:0] cfg_addr_dcache_gp  = 16'h0043;
    localparam logic [15:0] cfg_addr_cce_gp     = 16'h0081;

    // True for any address that decodes to a register (including read-only core_id)
    function automatic logic cfg_addr_known(input logic [15:0] addr);
        case (addr)
            cfg_addr_reset_gp, cfg_addr_freeze_gp, cfg_addr_core_id_gp,
            cfg_addr_icache_gp, cfg_addr_npc_lo_gp, cfg_addr_npc_hi_gp,
            cfg_addr_dcache_gp, cfg_addr_cce_gp: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bp_cfg_reset_sequencer.sv
// Per-core reset hold counter plus freeze forcing. A reset write of 0 holds
// the core in reset for reset_hold_cycles_p cycles before releasing it; while
// reset is asserted the freeze bit is pinned to 1.
module bp_cfg_reset_sequencer #(
    parameter int reset_hold_cycles_p = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic reset_we_i,
    input  logic reset_data_i,
    input  logic freeze_we_i,
    input  logic freeze_data_i,
    output logic core_reset_o,
    output logic freeze_o
);

    localparam int cnt_width_lp = $clog2(reset_hold_cycles_p + 1);

    logic [cnt_width_lp-1:0] cnt_reg;
    logic                    core_reset_reg;
    logic                    freeze_reg;

    // Countdown: reset drops on the same edge the counter reaches zero
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_reg        <= '0;
            core_reset_reg <= 1'b1;
            freeze_reg     <= 1'b1;
        end else begin
            if (reset_we_i) begin
                core_reset_reg <= 1'b1;
                cnt_reg        <= reset_data_i ? '0 : cnt_width_lp'(reset_hold_cycles_p);
            end else if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - cnt_width_lp'(1);
                if (cnt_reg == cnt_width_lp'(1))
                    core_reset_reg <= 1'b0;
            end

            if (core_reset_reg)
                freeze_reg <= 1'b1;
            else if (freeze_we_i)
                freeze_reg <= freeze_data_i;
        end
    end

    assign core_reset_o = core_reset_reg;
    assign freeze_o     = freeze_reg;

endmodule

// File: rtl/bp_cfg_link_regfile.sv
// Config-link endpoint for an N-core tile group: valid/ready request, one-cycle
// registered response, per-core reset/freeze/mode/npc registers, broadcast writes.
// Optional macro BP_CFG_LINK_READBACK_EN enables register readback; without it
// every read answers data=0, err=1.
module bp_cfg_link_regfile
    import bp_cfg_link_regfile_pkg::*;
#(
    parameter int num_core_p          = 4,
    parameter int cfg_addr_width_p    = 16,
    parameter int cfg_data_width_p    = 32,
    parameter int vaddr_width_p       = 39,
    parameter int reset_hold_cycles_p = 16,
    localparam int core_sel_width_lp  = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              cfg_v_i,
    output logic                              cfg_ready_o,
    input  logic                              cfg_w_i,
    input  logic                              cfg_bcast_i,
    input  logic [core_sel_width_lp-1:0]      cfg_core_sel_i,
    input  logic [cfg_addr_width_p-1:0]       cfg_addr_i,
    input  logic [cfg_data_width_p-1:0]       cfg_data_i,
    output logic                              cfg_v_o,
    output logic [cfg_data_width_p-1:0]       cfg_data_o,
    output logic                              cfg_err_o,
    output logic [num_core_p-1:0]             core_reset_o,
    output logic [num_core_p-1:0]             freeze_o,
    output logic [2*num_core_p-1:0]           icache_mode_o,
    output logic [2*num_core_p-1:0]           dcache_mode_o,
    output logic [num_core_p-1:0]             cce_mode_o,
    output logic [vaddr_width_p*num_core_p-1:0] npc_o
);

    bp_cfg_state_e               state_reg;
    logic                        ready_reg;
    logic                        resp_v_reg;
    logic [cfg_data_width_p-1:0] resp_data_reg;
    logic                        resp_err_reg;

    logic                        accept;
    logic                        sel_in_range;
    logic                        wr_err;
    logic                        rd_err;
    logic [cfg_data_width_p-1:0] rd_data;

    assign accept = cfg_v_i & ready_reg;

    // Write decode: broadcast writes bypass the core-select range check
    always_comb begin
        sel_in_range = (32'(cfg_core_sel_i) < num_core_p);
        wr_err       = ~cfg_addr_known(cfg_addr_i) | (~cfg_bcast_i & ~sel_in_range);
    end

    genvar gi;
    generate
        for (gi = 0; gi < num_core_p; gi++) begin : g_core
            bp_cache_mode_e             icache_mode_reg;
            bp_cache_mode_e             dcache_mode_reg;
            bp_cce_mode_e               cce_mode_reg;
            logic [vaddr_width_p-1:0]   npc_reg;
            logic                       core_we;

            assign core_we = accept & cfg_w_i & ~wr_err
                           & (cfg_bcast_i | (32'(cfg_core_sel_i) == gi));

            // Mode and npc registers of this core
            always_ff @(posedge clk_i) begin
                if (!reset_n_i) begin
                    icache_mode_reg <= e_cache_mode_normal;
                    dcache_mode_reg <= e_cache_mode_normal;
                    cce_mode_reg    <= e_cce_mode_normal;
                    npc_reg         <= '0;
                end else if (core_we) begin
                    case (cfg_addr_i)
                        cfg_addr_icache_gp: icache_mode_reg <= bp_cache_mode_e'(cfg_data_i[1:0]);
                        cfg_addr_dcache_gp: dcache_mode_reg <= bp_cache_mode_e'(cfg_data_i[1:0]);
                        cfg_addr_cce_gp:    cce_mode_reg    <= bp_cce_mode_e'(cfg_data_i[0]);
                        cfg_addr_npc_lo_gp: npc_reg[31:0]   <= cfg_data_i[31:0];
                        cfg_addr_npc_hi_gp: npc_reg[vaddr_width_p-1:32] <= cfg_data_i[vaddr_width_p-33:0];
                        default: ;
                    endcase
                end
            end

            bp_cfg_reset_sequencer #(
                .reset_hold_cycles_p(reset_hold_cycles_p)
            ) u_seq (
                .clk_i        (clk_i),
                .reset_n_i    (reset_n_i),
                .reset_we_i   (core_we & (cfg_addr_i == cfg_addr_reset_gp)),
                .reset_data_i (cfg_data_i[0]),
                .freeze_we_i  (core_we & (cfg_addr_i == cfg_addr_freeze_gp)),
                .freeze_data_i(cfg_data_i[0]),
                .core_reset_o (core_reset_o[gi]),
                .freeze_o     (freeze_o[gi])
            );

            assign icache_mode_o[2*gi +: 2]                   = icache_mode_reg;
            assign dcache_mode_o[2*gi +: 2]                   = dcache_mode_reg;
            assign cce_mode_o[gi]                             = cce_mode_reg;
            assign npc_o[vaddr_width_p*gi +: vaddr_width_p]   = npc_reg;
        end
    endgenerate

`ifdef BP_CFG_LINK_READBACK_EN
    logic [core_sel_width_lp-1:0] rd_idx;

    // Readback mux over the selected core; broadcast reads use cfg_core_sel_i
    always_comb begin
        rd_idx  = sel_in_range ? cfg_core_sel_i : '0;
        rd_err  = ~sel_in_range | ~cfg_addr_known(cfg_addr_i);
        rd_data = '0;
        case (cfg_addr_i)
            cfg_addr_reset_gp:   rd_data = cfg_data_width_p'(core_reset_o[rd_idx]);
            cfg_addr_freeze_gp:  rd_data = cfg_data_width_p'(freeze_o[rd_idx]);
            cfg_addr_core_id_gp: rd_data = cfg_data_width_p'(cfg_core_sel_i);
            cfg_addr_icache_gp:  rd_data = cfg_data_width_p'(icache_mode_o[2*rd_idx +: 2]);
            cfg_addr_dcache_gp:  rd_data = cfg_data_width_p'(dcache_mode_o[2*rd_idx +: 2]);
            cfg_addr_cce_gp:     rd_data = cfg_data_width_p'(cce_mode_o[rd_idx]);
            cfg_addr_npc_lo_gp:  rd_data = npc_o[vaddr_width_p*rd_idx +: 32];
            cfg_addr_npc_hi_gp:  rd_data = cfg_data_width_p'(npc_o[vaddr_width_p*rd_idx+32 +: vaddr_width_p-32]);
            default:             rd_data = '0;
        endcase
        if (rd_err)
            rd_data = '0;
    end
`else
    assign rd_err  = 1'b1;
    assign rd_data = '0;
`endif

    // Request/response FSM: accept in IDLE, present response for one cycle in RESP
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg     <= e_cfg_idle;
            ready_reg     <= 1'b0;
            resp_v_reg    <= 1'b0;
            resp_data_reg <= '0;
            resp_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                e_cfg_idle: begin
                    if (accept) begin
                        state_reg     <= e_cfg_resp;
                        ready_reg     <= 1'b0;
                        resp_v_reg    <= 1'b1;
                        resp_data_reg <= cfg_w_i ? '0 : rd_data;
                        resp_err_reg  <= cfg_w_i ? wr_err : rd_err;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                e_cfg_resp: begin
                    state_reg     <= e_cfg_idle;
                    ready_reg     <= 1'b1;
                    resp_v_reg    <= 1'b0;
                    resp_data_reg <= '0;
                    resp_err_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= e_cfg_idle;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready_o = ready_reg;
    assign cfg_v_o     = resp_v_reg;
    assign cfg_data_o  = resp_data_reg;
    assign cfg_err_o   = resp_err_reg;

endmodule
